// File: rtl/grp_event_scheduler.sv
// Round-robin scheduler sharing one event channel among NUM_GRP pixel-group arbiters.
// Each granted pixel address is registered with a timestamp into a valid/ready event word.
module grp_event_scheduler #(
  parameter int unsigned NUM_GRP  = 4,
  parameter int unsigned GADDR_W  = 2,
  parameter int unsigned PADDR_W  = 4,
  parameter int unsigned TS_W     = 16,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_i,
  input  logic [NUM_GRP-1:0]                  grp_req_i,
  input  logic [NUM_GRP-1:0]                  grp_active_i,
  input  logic [NUM_GRP*PADDR_W-1:0]          grp_x_add_i,
  input  logic [NUM_GRP*PADDR_W-1:0]          grp_y_add_i,
  input  logic [NUM_GRP-1:0]                  grp_release_i,
  output logic [NUM_GRP-1:0]                  grp_enable_o,
  output logic                                evt_valid_o,
  input  logic                                evt_ready_i,
  output logic [GADDR_W+2*PADDR_W+TS_W-1:0]   evt_data_o,
  output logic [GADDR_W-1:0]                  cur_grp_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int unsigned EvtW = GADDR_W + 2 * PADDR_W + TS_W;
  localparam int unsigned WdW  = $clog2(MAX_HOLD + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StServe, StHold, StRelease} state_e;

  state_e              state_q;
  logic [GADDR_W-1:0]  ptr_q, cur_grp_q;
  logic [TS_W-1:0]     ts_q;
  logic [NUM_GRP-1:0]  act_q, grp_enable_q;
  logic [WdW-1:0]      wd_q;
  logic                rel_pend_q, evt_valid_q, timeout_q;
  logic [EvtW-1:0]     evt_data_q;

  // First requester strictly after the pointer, searching circularly.
  logic [GADDR_W-1:0] pick, idx;
  logic               pick_vld;
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_GRP; k++) begin
      idx = GADDR_W'((32'(ptr_q) + k) % NUM_GRP);
      if (!pick_vld && grp_req_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  logic [NUM_GRP-1:0] pick_oh, cur_oh;
  logic               act_rise, rel_cur;
  logic [PADDR_W-1:0] x_cur, y_cur;

  assign pick_oh  = NUM_GRP'(1) << pick;
  assign cur_oh   = NUM_GRP'(1) << cur_grp_q;
  assign act_rise = grp_active_i[cur_grp_q] & ~act_q[cur_grp_q];
  assign rel_cur  = grp_release_i[cur_grp_q];
  assign x_cur    = grp_x_add_i[32'(cur_grp_q) * PADDR_W +: PADDR_W];
  assign y_cur    = grp_y_add_i[32'(cur_grp_q) * PADDR_W +: PADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= GADDR_W'(NUM_GRP - 1);
      cur_grp_q    <= '0;
      ts_q         <= '0;
      act_q        <= '0;
      grp_enable_q <= '0;
      wd_q         <= '0;
      rel_pend_q   <= 1'b0;
      evt_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      evt_data_q   <= '0;
    end else begin
      ts_q      <= ts_q + 1'b1;
      act_q     <= grp_active_i;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en_i && |grp_req_i) state_q <= StSelect;
        end
        StSelect: begin
          if (en_i && pick_vld) begin
            cur_grp_q    <= pick;
            grp_enable_q <= pick_oh;
            wd_q         <= '0;
            state_q      <= StServe;
          end else begin
            state_q <= StIdle;
          end
        end
        StServe: begin
          if (!en_i) begin
            grp_enable_q <= '0;
            state_q      <= StIdle;
          end else if (act_rise) begin
            // Capture beats a same-cycle release; the release is replayed after the handshake.
            evt_data_q   <= {cur_grp_q, x_cur, y_cur, ts_q};
            evt_valid_q  <= 1'b1;
            rel_pend_q   <= rel_cur;
            grp_enable_q <= '0;
            wd_q         <= '0;
            state_q      <= StHold;
          end else if (rel_cur) begin
            grp_enable_q <= '0;
            state_q      <= StRelease;
          end else if (wd_q == WdW'(MAX_HOLD - 1)) begin
            timeout_q    <= 1'b1;
            grp_enable_q <= '0;
            state_q      <= StRelease;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StHold: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            if (rel_pend_q || !en_i) begin
              state_q <= StRelease;
            end else begin
              grp_enable_q <= cur_oh;
              wd_q         <= '0;
              state_q      <= StServe;
            end
          end
        end
        StRelease: begin
          ptr_q      <= cur_grp_q;
          rel_pend_q <= 1'b0;
          state_q    <= (en_i && |grp_req_i) ? StSelect : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grp_enable_o = grp_enable_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_data_o   = evt_data_q;
  assign cur_grp_o    = cur_grp_q;
  assign busy_o       = (state_q != StIdle);
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_grp_event_scheduler.sv
// Randomized bench for grp_event_scheduler, compared cycle by cycle against a
// behavioural model of the scheduling rules.
module tb_grp_event_scheduler;

  localparam int NUM_GRP  = 4;
  localparam int GADDR_W  = 2;
  localparam int PADDR_W  = 4;
  localparam int TS_W     = 16;
  localparam int MAX_HOLD = 64;
  localparam int EW       = GADDR_W + 2 * PADDR_W + TS_W;
  localparam int XW       = NUM_GRP * PADDR_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic [NUM_GRP-1:0] req = '0, act = '0, rel = '0;
  logic [XW-1:0]      xa = '0, ya = '0;
  logic               ready = 1'b0;
  logic [NUM_GRP-1:0] grp_enable_o;
  logic               evt_valid_o, busy_o, timeout_o;
  logic [EW-1:0]      evt_data_o;
  logic [GADDR_W-1:0] cur_grp_o;

  grp_event_scheduler #(
    .NUM_GRP (NUM_GRP),
    .GADDR_W (GADDR_W),
    .PADDR_W (PADDR_W),
    .TS_W    (TS_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .grp_req_i    (req),
    .grp_active_i (act),
    .grp_x_add_i  (xa),
    .grp_y_add_i  (ya),
    .grp_release_i(rel),
    .grp_enable_o (grp_enable_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (ready),
    .evt_data_o   (evt_data_o),
    .cur_grp_o    (cur_grp_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: which group owns the channel and what that owner is doing this cycle.
  int unsigned        m_ts;
  int                 m_ptr, m_owner, m_serve_cycles;
  bit                 m_selecting, m_serving, m_releasing, m_pending_rel;
  bit [NUM_GRP-1:0]   m_prev_act;
  bit [NUM_GRP-1:0]   e_en;
  bit                 e_valid, e_timeout;
  logic [EW-1:0]      e_data;
  int                 dut_timeouts = 0, model_timeouts = 0;

  function automatic int next_requester(input int ptr, input logic [NUM_GRP-1:0] r);
    for (int k = 1; k <= NUM_GRP; k++) begin
      if (r[(ptr + k) % NUM_GRP]) return (ptr + k) % NUM_GRP;
    end
    return -1;
  endfunction

  function automatic bit m_busy();
    return m_selecting || m_serving || m_releasing || e_valid;
  endfunction

  task automatic model_reset();
    m_ts = 0; m_ptr = NUM_GRP - 1; m_owner = 0; m_serve_cycles = 0;
    m_selecting = 0; m_serving = 0; m_releasing = 0; m_pending_rel = 0;
    m_prev_act = '0; e_en = '0; e_valid = 0; e_timeout = 0; e_data = '0;
  endtask

  task automatic model_step();
    bit was_sel, was_srv, was_rel, was_hold, rise;
    int g;
    was_sel = m_selecting; was_srv = m_serving; was_rel = m_releasing; was_hold = e_valid;
    m_selecting = 0; m_serving = 0; m_releasing = 0; e_timeout = 0;
    if (was_sel) begin
      g = next_requester(m_ptr, req);
      if (en && g >= 0) begin
        m_owner = g; m_serving = 1; m_serve_cycles = 0;
      end
    end else if (was_srv) begin
      rise = act[m_owner] && !m_prev_act[m_owner];
      if (!en) begin
        // owner abandoned, scheduler idles
      end else if (rise) begin
        e_valid = 1;
        e_data = {GADDR_W'(m_owner), xa[m_owner*PADDR_W +: PADDR_W],
                  ya[m_owner*PADDR_W +: PADDR_W], TS_W'(m_ts)};
        m_pending_rel = rel[m_owner];
      end else if (rel[m_owner]) begin
        m_releasing = 1;
      end else begin
        m_serve_cycles++;
        if (m_serve_cycles == MAX_HOLD) begin
          e_timeout = 1; m_releasing = 1;
        end else begin
          m_serving = 1;
        end
      end
    end else if (was_hold) begin
      if (ready) begin
        e_valid = 0;
        if (m_pending_rel || !en) m_releasing = 1;
        else begin m_serving = 1; m_serve_cycles = 0; end
      end
    end else if (was_rel) begin
      m_ptr = m_owner; m_pending_rel = 0;
      m_selecting = en && (req != 0);
    end else begin
      m_selecting = en && (req != 0);
    end
    e_en = m_serving ? NUM_GRP'(1) << m_owner : '0;
    m_prev_act = act;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_outputs();
    check("grp_enable", 64'(grp_enable_o), 64'(e_en));
    check("evt_valid", 64'(evt_valid_o), 64'(e_valid));
    check("evt_data", 64'(evt_data_o), 64'(e_data));
    check("timeout", 64'(timeout_o), 64'(e_timeout));
    check("busy", 64'(busy_o), 64'(m_busy()));
    if (m_busy()) check("cur_grp", 64'(cur_grp_o), 64'(m_owner));
    if (timeout_o) dut_timeouts++;
    if (e_timeout) model_timeouts++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 64'({grp_enable_o, evt_valid_o, evt_data_o, cur_grp_o, busy_o,
                                timeout_o}), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [NUM_GRP-1:0] rand_vec(input int pct);
    logic [NUM_GRP-1:0] v;
    for (int i = 0; i < NUM_GRP; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  task automatic drive(input int mode);
    xa = XW'($urandom);
    ya = XW'($urandom);
    case (mode)
      0: begin
        en = ($urandom_range(99) < 97); req = rand_vec(60); act = rand_vec(30);
        rel = rand_vec(5); ready = ($urandom_range(99) < 60);
      end
      1: begin
        en = 1'b1; req = rand_vec(70); act = '0; rel = '0; ready = 1'b1;
      end
      2: begin
        en = 1'b1; req = '1; act = rand_vec(40); rel = rand_vec(50); ready = ($urandom_range(99) < 70);
      end
      default: begin
        en = ($urandom_range(99) < 80); req = rand_vec(60); act = rand_vec(40);
        rel = rand_vec(10); ready = ($urandom_range(99) < 15);
      end
    endcase
  endtask

  logic [EW-1:0] t1_exp;
  bit            saw_wrap = 0;
  int            guard;

  initial begin
    #2;
    reset_dut();

    // Single requester on group 2: enable two cycles after the idle sample, then one capture.
    en = 1'b1; req = 4'b0100; act = '0; rel = '0; ready = 1'b0;
    step();
    step();
    check("t1_enable", 64'(grp_enable_o), 64'(4'b0100));
    xa[2*PADDR_W +: PADDR_W] = 4'd3;
    ya[2*PADDR_W +: PADDR_W] = 4'd9;
    act = 4'b0100;
    step();
    t1_exp = {2'd2, 4'd3, 4'd9, 16'd2};
    check("t1_data", 64'(evt_data_o), 64'(t1_exp));
    check("t1_valid", 64'(evt_valid_o), 64'(1));
    // Stalled downstream with active held high: word frozen, group frozen, no recapture.
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_valid", 64'(evt_valid_o), 64'(1));
      check("t3_hold_data", 64'(evt_data_o), 64'(t1_exp));
      check("t3_hold_enable", 64'(grp_enable_o), 64'(0));
    end
    ready = 1'b1;
    step();

    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < ((seg % 4 == 1) ? 150 : 60); c++) begin
        drive(seg % 4);
        step();
      end
    end

    // Reach a serving state, then pull reset asynchronously mid-cycle.
    en = 1'b1; req = '1; act = '0; rel = '0; ready = 1'b1;
    guard = 0;
    while (!m_serving && guard < 20) begin
      step();
      guard++;
    end
    check("reach_serve", 64'(m_serving), 64'(1));
    #3;
    reset_dut();
    en = 1'b1; req = '1; act = '0;
    step();
    step();
    check("after_reset_grp0", 64'(grp_enable_o), 64'(4'b0001));

    // Idle until the timestamp is about to wrap, then produce events across the wrap.
    en = 1'b0; req = '0; act = '0; rel = '0;
    guard = 0;
    while (m_ts != 32'hFFF0 && guard < 70000) begin
      step();
      guard++;
    end
    en = 1'b1; req = '1; rel = '0; ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      act = (c % 2 == 1) ? '1 : '0;
      step();
      if (evt_valid_o && evt_data_o[TS_W-1:0] < 16) saw_wrap = 1;
    end
    check("ts_wrap_event", 64'(saw_wrap), 64'(1));
    check("timeout_count", 64'(dut_timeouts), 64'(model_timeouts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
